level_calibrator: RTL



---
 rtl/level_calibrator.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/level_calibrator.sv
// level_calibrator
//   Holds the empty/full calibration points of the liquid level meter and
//   converts each raw sensor sample into a 0..100 % fill level using a
//   sequential restoring divider with constant 10-cycle throughput.
//
// Ports
//   clk_100MHz  in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   raw_level   in   W  raw sensor sample
//   raw_valid   in   sample strobe
//   saveH_pulse in   store last sample as the full (100 %) point
//   saveL_pulse in   store last sample as the empty (0 %) point
//   clear_pulse in   discard calibration
//   level_pct   out  7  fill level 0..100, held between updates
//   pct_valid   out  one-cycle strobe when level_pct is updated
//   busy        out  conversion in progress, new samples are dropped
//   cal_ok      out  both points stored and hi > lo
//   cal_error   out  both points stored and hi <= lo
module level_calibrator #(
  parameter int W = 12
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic [W-1:0] raw_level,
  input  logic         raw_valid,
  input  logic         saveH_pulse,
  input  logic         saveL_pulse,
  input  logic         clear_pulse,
  output logic [6:0]   level_pct,
  output logic         pct_valid,
  output logic         busy,
  output logic         cal_ok,
  output logic         cal_error
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  localparam int NW = W + 7;  // numerator / remainder width, holds (raw-lo)*100

  state_t        state_q, state_d;
  logic [W-1:0]  last_raw_q, last_raw_d;
  logic          sample_seen_q, sample_seen_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          hi_set_q, hi_set_d;
  logic          lo_set_q, lo_set_d;
  logic          cal_ok_q, cal_ok_d;
  logic          cal_error_q, cal_error_d;
  // Snapshot of the conversion operands, frozen for the whole conversion
  logic [W-1:0]  raw_w_q, raw_w_d;
  logic [W-1:0]  hi_w_q, hi_w_d;
  logic [W-1:0]  lo_w_q, lo_w_d;
  // Divider datapath
  logic [W-1:0]  div_q, div_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [6:0]    quo_q, quo_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          clamp_q, clamp_d;
  logic [6:0]    clamp_val_q, clamp_val_d;
  // Registered outputs
  logic [6:0]    level_q, level_d;
  logic          pct_valid_q, pct_valid_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  diff;
  logic [NW-1:0] diff_ext;
  logic [NW-1:0] div_ext;
  logic [NW-1:0] trial;

  always_comb begin
    state_d       = state_q;
    last_raw_d    = last_raw_q;
    sample_seen_d = sample_seen_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    hi_set_d      = hi_set_q;
    lo_set_d      = lo_set_q;
    raw_w_d       = raw_w_q;
    hi_w_d        = hi_w_q;
    lo_w_d        = lo_w_q;
    div_d         = div_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    clamp_d       = clamp_q;
    clamp_val_d   = clamp_val_q;
    level_d       = level_q;

    diff     = raw_w_q - lo_w_q;
    diff_ext = {7'd0, diff};
    div_ext  = {7'd0, div_q};
    trial    = div_ext << cnt_q;

    // Outputs lag the state by one cycle: busy covers PREP..DONE as seen
    // from the following cycle, and the strobe coincides with level update.
    busy_d      = (state_q != IDLE);
    pct_valid_d = (state_q == DONE);

    // Sample capture runs regardless of conversion activity
    if (raw_valid) begin
      last_raw_d    = raw_level;
      sample_seen_d = 1'b1;
    end

    // Save-high and save-low are independent so both may land together;
    // clear overrides both. Saves use last_raw from before this cycle.
    if (clear_pulse) begin
      hi_set_d = 1'b0;
      lo_set_d = 1'b0;
    end else if (sample_seen_q) begin
      if (saveH_pulse) begin
        hi_d     = last_raw_q;
        hi_set_d = 1'b1;
      end
      if (saveL_pulse) begin
        lo_d     = last_raw_q;
        lo_set_d = 1'b1;
      end
    end

    cal_ok_d    = hi_set_q & lo_set_q & (hi_q > lo_q);
    cal_error_d = hi_set_q & lo_set_q & (hi_q <= lo_q);

    case (state_q)
      IDLE: begin
        if (raw_valid && cal_ok_q) begin
          raw_w_d = raw_level;
          hi_w_d  = hi_q;
          lo_w_d  = lo_q;
          state_d = PREP;
        end
      end
      PREP: begin
        div_d       = hi_w_q - lo_w_q;
        quo_d       = 7'd0;
        cnt_d       = 3'd6;
        clamp_d     = 1'b0;
        clamp_val_d = 7'd0;
        rem_d       = (diff_ext << 6) + (diff_ext << 5) + (diff_ext << 2);
        if (raw_w_q <= lo_w_q) begin
          clamp_d     = 1'b1;
          clamp_val_d = 7'd0;
          rem_d       = '0;
        end else if (raw_w_q >= hi_w_q) begin
          clamp_d     = 1'b1;
          clamp_val_d = 7'd100;
          rem_d       = '0;
        end
        state_d = DIV;
      end
      DIV: begin
        if (rem_q >= trial) begin
          rem_d = rem_q - trial;
          quo_d = quo_q | (7'd1 << cnt_q);
        end
        if (cnt_q == 3'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        level_d = clamp_q ? clamp_val_q : quo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      last_raw_q    <= '0;
      sample_seen_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      hi_set_q      <= 1'b0;
      lo_set_q      <= 1'b0;
      cal_ok_q      <= 1'b0;
      cal_error_q   <= 1'b0;
      raw_w_q       <= '0;
      hi_w_q        <= '0;
      lo_w_q        <= '0;
      div_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      clamp_q       <= 1'b0;
      clamp_val_q   <= '0;
      level_q       <= '0;
      pct_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_raw_q    <= last_raw_d;
      sample_seen_q <= sample_seen_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      hi_set_q      <= hi_set_d;
      lo_set_q      <= lo_set_d;
      cal_ok_q      <= cal_ok_d;
      cal_error_q   <= cal_error_d;
      raw_w_q       <= raw_w_d;
      hi_w_q        <= hi_w_d;
      lo_w_q        <= lo_w_d;
      div_q         <= div_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      clamp_q       <= clamp_d;
      clamp_val_q   <= clamp_val_d;
      level_q       <= level_d;
      pct_valid_q   <= pct_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign level_pct = level_q;
  assign pct_valid = pct_valid_q;
  assign busy      = busy_q;
  assign cal_ok    = cal_ok_q;
  assign cal_error = cal_error_q;

endmodule
